// File: rtl/sort_16x16b_unpack_chk.sv
// Streams a sorted 16x16b vector out one element per beat, flagging any out-of-order neighbour pair.
// First element appears 1 cycle after accept; beats hold while out_ready is low, and a new vector is taken on the last beat.
`timescale 1ns/1ps
module sort_16x16b_unpack_chk #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ELEM_W*N_ELEM-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_W-1:0]          out_data,
  output logic [$clog2(N_ELEM)-1:0]  out_idx,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       order_err,
  output logic [7:0]                 err_count
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state_q;
  logic [N_ELEM-1:0][ELEM_W-1:0]  vec_q;
  logic [N_ELEM-1:0][ELEM_W-1:0]  in_elems;
  logic [IDX_W-1:0]               idx_q;
  logic                           order_err_q;
  logic                           order_err_d;
  logic [7:0]                     cnt_q;
  logic                           accept;
  logic                           beat;

  assign in_elems  = in_data;
  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_data  = out_valid ? vec_q[idx_q] : '0;
  assign out_first = out_valid && (idx_q == '0);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign order_err = order_err_q;
  assign err_count = cnt_q;

  assign beat     = out_valid && out_ready;
  assign in_ready = (state_q == IDLE) || (beat && out_last);
  assign accept   = in_valid && in_ready;

  // Equal neighbours are legal; only a strict decrease is an error.
  always_comb begin
    order_err_d = 1'b0;
    for (int k = 1; k < N_ELEM; k++) begin
      if (in_elems[k] < in_elems[k-1]) order_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      idx_q       <= '0;
      order_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (beat && out_last && order_err_q && (cnt_q != 8'hFF)) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (accept) begin
        state_q     <= SEND;
        vec_q       <= in_elems;
        idx_q       <= '0;
        order_err_q <= order_err_d;
      end else if (beat) begin
        if (out_last) begin
          state_q     <= IDLE;
          idx_q       <= '0;
          order_err_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_16x16b_unpack_chk.sv
// Directed bench for sort_16x16b_unpack_chk: vector table plus back-to-back, mid-vector reset and saturation sequences.
`timescale 1ns/1ps
module tb_sort_16x16b_unpack_chk;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [3:0]   out_idx;
  logic         out_first;
  logic         out_last;
  logic         order_err;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] vec;
    logic         exp_err;
    logic [7:0]   exp_cnt;
  } vec_rec_t;

  vec_rec_t tbl[5];

  sort_16x16b_unpack_chk #(.ELEM_W(16), .N_ELEM(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_first (out_first),
    .out_last  (out_last),
    .order_err (order_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_asc();
    logic [255:0] v;
    for (int k = 0; k < 16; k++) v[16*k +: 16] = 16'(16*k + 1);
    return v;
  endfunction

  function automatic logic [15:0] elem(input logic [255:0] v, input int k);
    return v[16*k +: 16];
  endfunction

  // Offers one vector from IDLE with out_ready high and checks all 16 beats.
  task automatic send_vec(input logic [255:0] v, input logic exp_err, input logic [7:0] exp_cnt);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = v;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 0; k < 16; k++) begin
      chk("beat_valid", {31'd0, out_valid}, 32'd1);
      chk("beat_idx",   {28'd0, out_idx}, 32'(k));
      chk("beat_data",  {16'd0, out_data}, {16'd0, elem(v, k)});
      chk("beat_first", {31'd0, out_first}, {31'd0, (k == 0)});
      chk("beat_last",  {31'd0, out_last}, {31'd0, (k == 15)});
      chk("beat_err",   {31'd0, order_err}, {31'd0, exp_err});
      @(posedge clk); #1;
    end
    chk("post_valid",  {31'd0, out_valid}, 32'd0);
    chk("post_data",   {16'd0, out_data}, 32'd0);
    chk("post_err",    {31'd0, order_err}, 32'd0);
    chk("post_count",  {24'd0, err_count}, {24'd0, exp_cnt});
  endtask

  initial begin
    logic [255:0] asc, ffff, bad, desc, tail, vb;
    int  exp_idx;
    bit  reached;
    int  exp_cnt;

    asc = mk_asc();
    ffff = {16{16'hFFFF}};
    bad = asc;
    bad[16*5 +: 16] = 16'h0100;
    bad[16*6 +: 16] = 16'h00FF;
    for (int k = 0; k < 16; k++) desc[16*k +: 16] = 16'(16'hF000 - k);
    tail = {16{16'h1234}};
    tail[16*15 +: 16] = 16'h1233;

    tbl[0] = '{vec: asc,  exp_err: 1'b0, exp_cnt: 8'd0};
    tbl[1] = '{vec: ffff, exp_err: 1'b0, exp_cnt: 8'd0};
    tbl[2] = '{vec: bad,  exp_err: 1'b1, exp_cnt: 8'd1};
    tbl[3] = '{vec: desc, exp_err: 1'b1, exp_cnt: 8'd2};
    tbl[4] = '{vec: tail, exp_err: 1'b1, exp_cnt: 8'd3};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, out_data}, 32'd0);
    chk("rst_out_idx",   {28'd0, out_idx}, 32'd0);
    chk("rst_first",     {31'd0, out_first}, 32'd0);
    chk("rst_last",      {31'd0, out_last}, 32'd0);
    chk("rst_order_err", {31'd0, order_err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) send_vec(tbl[i].vec, tbl[i].exp_err, tbl[i].exp_cnt);

    // Two queued vectors, in_valid held: 32 beats with no bubble.
    vb = ffff;
    in_valid = 1'b1;
    in_data = asc;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = vb;
    for (int b = 0; b < 32; b++) begin
      chk("b2b_valid",    {31'd0, out_valid}, 32'd1);
      chk("b2b_idx",      {28'd0, out_idx}, 32'(b % 16));
      chk("b2b_data",     {16'd0, out_data}, {16'd0, (b < 16) ? elem(asc, b) : elem(vb, b - 16)});
      chk("b2b_in_ready", {31'd0, in_ready}, {31'd0, (b % 16 == 15)});
      if (b == 31) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_done_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_count", {24'd0, err_count}, 32'd3);

    // Random stalls, then reset while out_idx is 7.
    in_valid = 1'b1;
    in_data = bad;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_idx = 0;
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      chk("stall_idx",  {28'd0, out_idx}, 32'(exp_idx));
      chk("stall_data", {16'd0, out_data}, {16'd0, elem(bad, exp_idx)});
      chk("stall_err",  {31'd0, order_err}, 32'd1);
      if (exp_idx == 7) begin
        reached = 1'b1;
        break;
      end
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (out_ready) exp_idx++;
    end
    chk("reach_idx7", {31'd0, reached}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_valid",    {31'd0, out_valid}, 32'd0);
    chk("midrst_idx",      {28'd0, out_idx}, 32'd0);
    chk("midrst_count",    {24'd0, err_count}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("midrst_hold_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    send_vec(asc, 1'b0, 8'd0);

    // 300 bad vectors back to back: count saturates at 255.
    in_valid = 1'b1;
    in_data = bad;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 4800; b++) begin
      if (b == 4799) in_valid = 1'b0;
      @(posedge clk); #1;
      if (b % 16 == 15) begin
        exp_cnt = (b + 1) / 16;
        if (exp_cnt > 255) exp_cnt = 255;
        chk("sat_count", {24'd0, err_count}, 32'(exp_cnt));
      end
    end
    chk("sat_done_valid", {31'd0, out_valid}, 32'd0);
    chk("sat_final", {24'd0, err_count}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_16x16b_unpack_chk.md
SORT_16X16B_UNPACK_CHK -- requirements
Module: sort_16x16b_unpack_chk

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 16, meaning element width in bits; only 16 is supported.
REQ-002 The block SHALL have parameter N_ELEM, default 16, meaning elements per vector; only 16 is supported.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1, the vector on in_data is offered.
REQ-007 The block SHALL have port in_ready, output, 1, the block accepts a vector this cycle.
REQ-008 The block SHALL have port in_data, input, 256, sorted-network output vector; element k = in_data[16k+15:16k].
REQ-009 The block SHALL have port out_valid, output, 1, out_* fields hold a valid element.
REQ-010 The block SHALL have port out_ready, input, 1, the downstream consumer accepts the element.
REQ-011 The block SHALL have port out_data, output, 16, the current element.
REQ-012 The block SHALL have port out_idx, output, 4, the index k of the current element.
REQ-013 The block SHALL have port out_first, output, 1, high when out_idx = 0.
REQ-014 The block SHALL have port out_last, output, 1, high when out_idx = 15.
REQ-015 The block SHALL have port order_err, output, 1, the current vector is not non-decreasing.
REQ-016 The block SHALL have port err_count, output, 8, count of vectors with order_err, saturating.

Function
REQ-017 The block SHALL implement exactly two states: IDLE (no vector held) and SEND (vector held, streaming).
REQ-018 A vector SHALL be accepted on any cycle where in_valid and in_ready are both high.
REQ-019 in_ready SHALL be high in IDLE, and in SEND only when out_valid, out_ready and out_last are all high, giving zero-bubble back-to-back vectors.
REQ-020 On acceptance, the block SHALL register in_data, set the index to 0, and be in SEND on the next cycle with out_valid high (1-cycle latency from accept to first element).
REQ-021 In SEND, out_valid SHALL be high; when out_valid and out_ready are high, the index SHALL increment by 1.
REQ-022 A beat accepted with out_last high SHALL go to IDLE, or stay in SEND with index 0 and the new vector if a vector is accepted in the same cycle.
REQ-023 out_data, out_idx and out_first/out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-024 out_data SHALL equal element out_idx of the held vector; elements are emitted in order 0..15, lowest index (smallest value) first.
REQ-025 At acceptance, the block SHALL compute order_err as the OR over k=1..15 of (element k < element k-1), using unsigned compare; equal neighbours are legal.
REQ-026 order_err SHALL be registered and held constant for all 16 beats of that vector.
REQ-027 err_count SHALL increment by 1 when a beat with out_last and order_err high is accepted, and SHALL saturate at 255.
REQ-028 Outside SEND, out_data, out_idx, out_first, out_last and order_err SHALL be 0.
REQ-029 in_data SHALL be ignored when in_ready is low, and in_valid SHALL NOT be required to stay high.

Reset
REQ-030 While rst is high, the block SHALL be in IDLE with in_ready=1, out_valid=0, out_data=0, out_idx=0, out_first=0, out_last=0, order_err=0 and err_count=0.
REQ-031 Reset asserted mid-vector SHALL discard the held vector immediately; no remaining elements are emitted and err_count is cleared.
REQ-032 After rst deasserts, the first vector SHALL be accepted on the first rising edge with in_valid high.

Verification
REQ-033 The bench SHALL drive ascending vector k -> 16*k+1 (0x0001..0x00F1) with out_ready held high -> 16 beats, out_idx 0..15, out_data 0x0001..0x00F1, order_err=0, err_count=0.
REQ-034 The bench SHALL drive all elements 0xFFFF -> order_err=0 (equal neighbours are legal), out_first only on beat 0 and out_last only on beat 15.
REQ-035 The bench SHALL drive a vector with element5=0x0100 and element6=0x00FF -> order_err=1 on all 16 beats, and err_count goes 0->1 on the accepted last beat.
REQ-036 The bench SHALL hold in_valid high with two vectors queued and out_ready high -> 32 consecutive valid beats with no bubble, and in_ready pulses only on each last beat.
REQ-037 The bench SHALL apply random out_ready stalls, then assert rst at out_idx=7 -> out_valid=0 in the same cycle, err_count=0, and a new vector restarts at idx 0.
REQ-038 The bench SHALL send 300 bad vectors -> err_count saturates at 255 and does not wrap.
